// File: rtl/branch_predict_ctrl_if.sv
// Fetch/execute side signals of the branch redirect controller.
// The pipeline is the master and the controller is the slave.
interface branch_predict_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      if_pc;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             ex_valid;
    logic             ex_is_branch;
    logic [31:0]      ex_pc;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             ex_pred_taken;
    logic [31:0]      ex_pred_target;
    logic             flush;
    logic [31:0]      pc_branch;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, flush, pc_branch, br_cnt, mispred_cnt
    );

    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, flush, pc_branch, br_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Fetch-redirect controller: direct-mapped BTB with 2-bit counters predicts
// for the fetch PC, and EX resolution updates the table and raises flush.
module branch_predict_ctrl #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_predict_ctrl_if.slave  bus
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       cnt;
    } entry_t;

    localparam entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, cnt: 2'b01};

    entry_t           btb_q [ENTRIES];
    entry_t           btb_d [ENTRIES];
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // Lookup reads only the registered table, so a same-cycle update is not bypassed.
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    entry_t           if_ent;
    logic             if_hit;

    assign if_idx = bus.if_pc[IDX_W+1:2];
    assign if_tag = bus.if_pc[31:IDX_W+2];
    assign if_ent = btb_q[if_idx];
    assign if_hit = if_ent.valid && (if_ent.tag == if_tag);

    assign bus.pred_taken  = if_hit && if_ent.cnt[1];
    assign bus.pred_target = if_hit ? if_ent.target : bus.if_pc + 32'd4;

    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    entry_t           ex_ent;
    logic             ex_hit;
    logic             res;
    logic             mis_br;
    logic             mis_nb;
    logic             flush;

    assign ex_idx = bus.ex_pc[IDX_W+1:2];
    assign ex_tag = bus.ex_pc[31:IDX_W+2];
    assign ex_ent = btb_q[ex_idx];
    assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);

    assign res    = bus.ex_valid && bus.ex_is_branch;
    assign mis_br = res && ((bus.ex_taken != bus.ex_pred_taken) ||
                            (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
    // A non-branch fetched with a taken prediction hit a stale/aliased entry.
    assign mis_nb = bus.ex_valid && !bus.ex_is_branch && bus.ex_pred_taken;
    assign flush  = mis_br || mis_nb;

    assign bus.flush       = flush;
    assign bus.pc_branch   = (res && bus.ex_taken) ? bus.ex_target : bus.ex_pc + 32'd4;
    assign bus.br_cnt      = br_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;

    always_comb begin
        btb_d = btb_q;
        if (res) begin
            if (ex_hit) begin
                if (bus.ex_taken) begin
                    if (ex_ent.cnt != 2'b11) btb_d[ex_idx].cnt = ex_ent.cnt + 2'b01;
                    btb_d[ex_idx].target = bus.ex_target;
                end else if (ex_ent.cnt != 2'b00) begin
                    btb_d[ex_idx].cnt = ex_ent.cnt - 2'b01;
                end
            end else if (bus.ex_taken) begin
                btb_d[ex_idx] = '{valid: 1'b1, tag: ex_tag, target: bus.ex_target, cnt: 2'b10};
            end
        end else if (mis_nb) begin
            btb_d[ex_idx].valid = 1'b0;
        end
    end

    always_comb begin
        br_cnt_d      = br_cnt_q + CNT_W'(res);
        mispred_cnt_d = mispred_cnt_q + CNT_W'(flush);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) btb_q[i] <= ENTRY_RST;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) btb_q[i] <= btb_d[i];
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed table of per-cycle vectors plus a counter-wrap sequence for
// branch_predict_ctrl (counters narrowed to 4 bits so wrap is reachable).
module tb_branch_predict_ctrl;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predict_ctrl_if #(.CNT_W(CW)) bus ();

    branch_predict_ctrl #(.IDX_W(4), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        bit          rst;
        bit          chk;
        logic        exv;
        logic        exb;
        logic [31:0] expc;
        logic        ext;
        logic [31:0] extgt;
        logic        expt;
        logic [31:0] exptgt;
        logic [31:0] ifpc;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_fl;
        logic [31:0] e_pcb;
        int          e_br;
        int          e_mis;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=0x%0h expected=0x%0h", name, row, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, bit c, logic v, logic b, logic [31:0] pc, logic t,
                                logic [31:0] tg, logic pt, logic [31:0] ptg,
                                logic [31:0] ifp, logic ept, logic [31:0] eptg,
                                logic efl, logic [31:0] epcb, int ebr, int emis);
        vec_t x;
        x.rst = r;  x.chk = c;  x.exv = v;  x.exb = b;  x.expc = pc;  x.ext = t;
        x.extgt = tg;  x.expt = pt;  x.exptgt = ptg;  x.ifpc = ifp;  x.e_pt = ept;
        x.e_ptgt = eptg;  x.e_fl = efl;  x.e_pcb = epcb;  x.e_br = ebr;  x.e_mis = emis;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        rst                = x.rst;
        bus.ex_valid       = x.exv;
        bus.ex_is_branch   = x.exb;
        bus.ex_pc          = x.expc;
        bus.ex_taken       = x.ext;
        bus.ex_target      = x.extgt;
        bus.ex_pred_taken  = x.expt;
        bus.ex_pred_target = x.exptgt;
        bus.if_pc          = x.ifpc;
    endtask

    task automatic compare(input vec_t x, input int row);
        check("pred_taken",  row, 32'(bus.pred_taken), 32'(x.e_pt));
        check("pred_target", row, bus.pred_target, x.e_ptgt);
        check("flush",       row, 32'(bus.flush), 32'(x.e_fl));
        check("pc_branch",   row, bus.pc_branch, x.e_pcb);
        check("br_cnt",      row, 32'(bus.br_cnt), 32'(x.e_br % (1 << CW)));
        check("mispred_cnt", row, 32'(bus.mispred_cnt), 32'(x.e_mis % (1 << CW)));
    endtask

    vec_t vt [23];

    initial begin
        //            rst chk v  b  ex_pc   tk tgt     ptk ptgt    if_pc   e_pt e_ptgt  fl pc_branch br mis
        vt[0]  = mk(1, 0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h40, 0, 32'h44,  0, 32'h4,   0, 0);
        vt[1]  = mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h40, 0, 32'h44,  0, 32'h4,   0, 0);
        vt[2]  = mk(0, 1, 1, 1, 32'h40,  1, 32'h100, 0, 32'h44,  32'h40, 0, 32'h44,  1, 32'h100, 0, 0);
        vt[3]  = mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h40, 1, 32'h100, 0, 32'h4,   1, 1);
        vt[4]  = mk(0, 1, 1, 1, 32'h40,  0, 32'h0,   1, 32'h100, 32'h40, 1, 32'h100, 1, 32'h44,  1, 1);
        vt[5]  = mk(0, 1, 1, 1, 32'h40,  0, 32'h0,   0, 32'h44,  32'h40, 0, 32'h100, 0, 32'h44,  2, 2);
        vt[6]  = mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h40, 0, 32'h100, 0, 32'h4,   3, 2);
        vt[7]  = mk(0, 1, 1, 1, 32'h40,  1, 32'h100, 0, 32'h44,  32'h40, 0, 32'h100, 1, 32'h100, 3, 2);
        vt[8]  = mk(0, 1, 1, 1, 32'h40,  1, 32'h100, 0, 32'h44,  32'h40, 0, 32'h100, 1, 32'h100, 4, 3);
        vt[9]  = mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h40, 1, 32'h100, 0, 32'h4,   5, 4);
        vt[10] = mk(0, 1, 1, 0, 32'h440, 0, 32'h0,   1, 32'h100, 32'h40, 1, 32'h100, 1, 32'h444, 5, 4);
        vt[11] = mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h40, 0, 32'h44,  0, 32'h4,   5, 5);
        vt[12] = mk(0, 1, 1, 1, 32'h40,  1, 32'h100, 0, 32'h44,  32'h80, 0, 32'h84,  1, 32'h100, 5, 5);
        vt[13] = mk(0, 1, 1, 1, 32'h40,  1, 32'h200, 1, 32'h100, 32'h40, 1, 32'h100, 1, 32'h200, 6, 6);
        vt[14] = mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h40, 1, 32'h200, 0, 32'h4,   7, 7);
        vt[15] = mk(0, 1, 1, 1, 32'h40,  1, 32'h200, 1, 32'h200, 32'h40, 1, 32'h200, 0, 32'h200, 7, 7);
        vt[16] = mk(0, 1, 0, 1, 32'h40,  1, 32'h300, 1, 32'h100, 32'h40, 1, 32'h200, 0, 32'h44,  8, 7);
        vt[17] = mk(1, 1, 1, 1, 32'h80,  1, 32'h300, 0, 32'h84,  32'h80, 0, 32'h84,  1, 32'h300, 8, 7);
        vt[18] = mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h40, 0, 32'h44,  0, 32'h4,   0, 0);
        vt[19] = mk(0, 1, 1, 1, 32'h1C,  1, 32'h500, 0, 32'h20,  32'h1C, 0, 32'h20,  1, 32'h500, 0, 0);
        vt[20] = mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h1C, 1, 32'h500, 0, 32'h4,   1, 1);
        vt[21] = mk(0, 1, 1, 0, 32'h1C,  0, 32'h0,   0, 32'h0,   32'h1C, 1, 32'h500, 0, 32'h20,  1, 1);
        vt[22] = mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h80, 0, 32'h84,  0, 32'h4,   1, 1);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(vt[i]);
            #1;
            if (vt[i].chk) compare(vt[i], i);
        end

        // Counter wrap: 16 more mispredicted not-taken resolves on a missing entry.
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            drive(mk(0, 1, 1, 1, 32'h200, 0, 32'h0, 1, 32'h300, 32'h200, 0, 32'h204,
                     1, 32'h204, 0, 0));
            #1;
            check("wrap_flush", 100 + n, 32'(bus.flush), 32'd1);
            check("wrap_miss_nowrite", 100 + n, 32'(bus.pred_taken), 32'd0);
            check("wrap_br_cnt", 100 + n, 32'(bus.br_cnt), 32'((1 + n - 1) % 16));
            check("wrap_mis_cnt", 100 + n, 32'(bus.mispred_cnt), 32'((1 + n - 1) % 16));
        end
        @(negedge clk);
        drive(mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h200, 0, 32'h204, 0, 32'h4, 1, 1));
        #1;
        check("wrap_final_br", 200, 32'(bus.br_cnt), 32'd1);
        check("wrap_final_mis", 200, 32'(bus.mispred_cnt), 32'd1);
        check("wrap_pred_target", 200, bus.pred_target, 32'h204);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
